// File: rtl/alarm_match_controller_if.sv
// Alarm controller bus: comparator-chain outputs, user controls and alarm status.
// The master side drives the inputs; the controller attaches through the slave modport.
interface alarm_match_controller_if #(
  parameter int MAX_SNOOZE = 3
);
  localparam int SLW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  logic           tick_1hz;
  logic           cmp_gt;
  logic           cmp_lt;
  logic           cmp_eq;
  logic           alarm_en;
  logic           snooze_btn;
  logic           stop_btn;
  logic           alarm_active;
  logic           snoozing;
  logic           buzzer;
  logic [SLW-1:0] snooze_left;

  modport master (
    output tick_1hz, cmp_gt, cmp_lt, cmp_eq, alarm_en, snooze_btn, stop_btn,
    input  alarm_active, snoozing, buzzer, snooze_left
  );

  modport slave (
    input  tick_1hz, cmp_gt, cmp_lt, cmp_eq, alarm_en, snooze_btn, stop_btn,
    output alarm_active, snoozing, buzzer, snooze_left
  );
endinterface

// File: rtl/alarm_match_controller.sv
// Alarm sequencer fed by a cascaded 4-bit magnitude comparator chain.
// It registers the chain's gt/lt/eq outputs and detects the start of a time match.
// An FSM then rings, snoozes, stops or times out, counting durations in 1 Hz ticks.
module alarm_match_controller #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  alarm_match_controller_if.slave  bus
);
  localparam int SLW    = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  localparam int MAXDUR = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS;
  localparam int CW     = $clog2(MAXDUR + 1);

  localparam logic [CW-1:0]  RING_LAST   = CW'(RING_SECONDS - 1);
  localparam logic [CW-1:0]  SNOOZE_LAST = CW'(SNOOZE_SECONDS - 1);
  localparam logic [SLW-1:0] SNOOZE_INIT = SLW'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RINGING = 2'b01,
    SNOOZE  = 2'b10
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic           buzzer_q;
  logic           active_q;
  logic           snoozing_q;
  logic [SLW-1:0] left_q;

  logic gt_q, lt_q, eq_q;
  logic match_d;
  logic snooze_d, stop_d;
  logic match_q, match_rise, snooze_rise, stop_rise;

  // Capture the comparator chain and keep one-cycle history for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      match_d  <= 1'b0;
      snooze_d <= 1'b0;
      stop_d   <= 1'b0;
    end else begin
      gt_q     <= bus.cmp_gt;
      lt_q     <= bus.cmp_lt;
      eq_q     <= bus.cmp_eq;
      match_d  <= match_q;
      snooze_d <= bus.snooze_btn;
      stop_d   <= bus.stop_btn;
    end
  end

  // Only a clean "equal" from the chain counts as a match; any other combination does not.
  assign match_q     = eq_q & ~gt_q & ~lt_q;
  assign match_rise  = match_q & ~match_d;
  assign snooze_rise = bus.snooze_btn & ~snooze_d;
  assign stop_rise   = bus.stop_btn & ~stop_d;

  // Alarm FSM with registered status outputs; branch order sets the priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      buzzer_q   <= 1'b0;
      active_q   <= 1'b0;
      snoozing_q <= 1'b0;
      left_q     <= SNOOZE_INIT;
    end else begin
      case (state_q)
        IDLE: begin
          if (match_rise && bus.alarm_en) begin
            state_q    <= RINGING;
            cnt_q      <= '0;
            buzzer_q   <= 1'b1;
            active_q   <= 1'b1;
            snoozing_q <= 1'b0;
            left_q     <= SNOOZE_INIT;
          end
        end

        RINGING: begin
          if (!bus.alarm_en || stop_rise) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            buzzer_q   <= 1'b0;
            active_q   <= 1'b0;
            snoozing_q <= 1'b0;
          end else if (snooze_rise && (left_q != '0)) begin
            state_q    <= SNOOZE;
            cnt_q      <= '0;
            buzzer_q   <= 1'b0;
            active_q   <= 1'b0;
            snoozing_q <= 1'b1;
            left_q     <= left_q - 1'b1;
          end else if (bus.tick_1hz && (cnt_q == RING_LAST)) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            buzzer_q   <= 1'b0;
            active_q   <= 1'b0;
            snoozing_q <= 1'b0;
          end else if (bus.tick_1hz) begin
            cnt_q    <= cnt_q + 1'b1;
            buzzer_q <= ~buzzer_q;
          end
        end

        SNOOZE: begin
          if (!bus.alarm_en || stop_rise) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            buzzer_q   <= 1'b0;
            active_q   <= 1'b0;
            snoozing_q <= 1'b0;
          end else if (bus.tick_1hz && (cnt_q == SNOOZE_LAST)) begin
            state_q    <= RINGING;
            cnt_q      <= '0;
            buzzer_q   <= 1'b1;
            active_q   <= 1'b1;
            snoozing_q <= 1'b0;
          end else if (bus.tick_1hz) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q    <= IDLE;
          cnt_q      <= '0;
          buzzer_q   <= 1'b0;
          active_q   <= 1'b0;
          snoozing_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.alarm_active = active_q;
  assign bus.snoozing     = snoozing_q;
  assign bus.buzzer       = buzzer_q;
  assign bus.snooze_left  = left_q;

endmodule

// File: tb/tb_alarm_match_controller.sv
// Scoreboard bench for alarm_match_controller (RING=4, SNOOZE=3, MAX_SNOOZE=2, tick every 10 clk).
// Stimulus queues the hand-derived output tuple for every clock; a monitor compares on the falling edge.
module tb_alarm_match_controller;
  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  alarm_match_controller_if #(.MAX_SNOOZE(2)) bus_if ();

  alarm_match_controller #(
    .RING_SECONDS   (4),
    .SNOOZE_SECONDS (3),
    .MAX_SNOOZE     (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    int         cyc;
    int         tid;
    logic       act;
    logic       snz;
    logic       buz;
    logic [1:0] left;
  } exp_t;

  exp_t sb_q[$];

  logic       e_act;
  logic       e_snz;
  logic       e_buz;
  logic [1:0] e_left;
  int         phase;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges so every expectation can be stamped with its cycle.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string tname(input int tid);
    case (tid)
      0:       return "reset";
      1:       return "t1_ring";
      2:       return "t2_retrigger";
      3:       return "t3_snooze";
      4:       return "t4_stop";
      5:       return "t5_nomatch";
      default: return "t6_rst_en";
    endcase
  endfunction

  task automatic check_output(input int tid, input int at, input logic [4:0] got, input logic [4:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL outputs_%s cyc=%0d got act/snz/buz/left=%b/%b/%b/%0d expected %b/%b/%b/%0d",
               tname(tid), at, got[4], got[3], got[2], got[1:0], want[4], want[3], want[2], want[1:0]);
    end
  endtask

  // Pop every expectation due this cycle and compare it with the DUT outputs.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      if (e.cyc != cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL stale_%s due=%0d seen=%0d", tname(e.tid), e.cyc, cyc);
      end else begin
        check_output(e.tid, cyc,
                     {bus_if.alarm_active, bus_if.snoozing, bus_if.buzzer, bus_if.snooze_left},
                     {e.act, e.snz, e.buz, e.left});
      end
    end
  end

  task automatic set_exp(input logic a, input logic s, input logic b, input logic [1:0] l);
    e_act  = a;
    e_snz  = s;
    e_buz  = b;
    e_left = l;
  endtask

  // Advance one clock and queue the expected outputs after that edge.
  task automatic apply_stimulus();
    exp_t e;
    @(posedge clk);
    #1;
    e.cyc  = cyc;
    e.tid  = phase;
    e.act  = e_act;
    e.snz  = e_snz;
    e.buz  = e_buz;
    e.left = e_left;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus();
  endtask

  task automatic tick_to(input logic a, input logic s, input logic b, input logic [1:0] l);
    idle(9);
    bus_if.tick_1hz = 1'b1;
    set_exp(a, s, b, l);
    apply_stimulus();
    bus_if.tick_1hz = 1'b0;
  endtask

  task automatic trigger();
    bus_if.cmp_eq = 1'b1;
    apply_stimulus();
    set_exp(1'b1, 1'b0, 1'b1, 2'd2);
    apply_stimulus();
  endtask

  task automatic snooze_press(input logic [1:0] l_after);
    bus_if.snooze_btn = 1'b1;
    set_exp(1'b0, 1'b1, 1'b0, l_after);
    apply_stimulus();
    bus_if.snooze_btn = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    phase  = 0;
    rst    = 1'b1;
    bus_if.tick_1hz   = 1'b0;
    bus_if.cmp_gt     = 1'b0;
    bus_if.cmp_lt     = 1'b0;
    bus_if.cmp_eq     = 1'b0;
    bus_if.alarm_en   = 1'b0;
    bus_if.snooze_btn = 1'b0;
    bus_if.stop_btn   = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 2'd2);
    idle(3);
    rst = 1'b0;
    idle(5);

    phase = 1;
    bus_if.alarm_en = 1'b1;
    idle(1);
    trigger();
    tick_to(1'b1, 1'b0, 1'b0, 2'd2);
    tick_to(1'b1, 1'b0, 1'b1, 2'd2);
    tick_to(1'b1, 1'b0, 1'b0, 2'd2);
    tick_to(1'b0, 1'b0, 1'b0, 2'd2);

    phase = 2;
    idle(200);
    bus_if.cmp_eq = 1'b0;
    idle(3);
    trigger();

    phase = 3;
    snooze_press(2'd1);
    tick_to(1'b0, 1'b1, 1'b0, 2'd1);
    tick_to(1'b0, 1'b1, 1'b0, 2'd1);
    tick_to(1'b1, 1'b0, 1'b1, 2'd1);
    snooze_press(2'd0);
    tick_to(1'b0, 1'b1, 1'b0, 2'd0);
    tick_to(1'b0, 1'b1, 1'b0, 2'd0);
    tick_to(1'b1, 1'b0, 1'b1, 2'd0);
    idle(2);
    bus_if.snooze_btn = 1'b1;
    apply_stimulus();
    bus_if.snooze_btn = 1'b0;
    idle(2);
    tick_to(1'b1, 1'b0, 1'b0, 2'd0);
    tick_to(1'b1, 1'b0, 1'b1, 2'd0);
    tick_to(1'b1, 1'b0, 1'b0, 2'd0);
    tick_to(1'b0, 1'b0, 1'b0, 2'd0);

    phase = 4;
    bus_if.cmp_eq = 1'b0;
    idle(2);
    trigger();
    tick_to(1'b1, 1'b0, 1'b0, 2'd2);
    idle(9);
    bus_if.tick_1hz = 1'b1;
    bus_if.stop_btn = 1'b1;
    set_exp(1'b0, 1'b0, 1'b0, 2'd2);
    apply_stimulus();
    bus_if.tick_1hz = 1'b0;
    idle(50);
    bus_if.stop_btn = 1'b0;
    bus_if.cmp_eq = 1'b0;
    idle(2);
    trigger();
    tick_to(1'b1, 1'b0, 1'b0, 2'd2);
    tick_to(1'b1, 1'b0, 1'b1, 2'd2);
    tick_to(1'b1, 1'b0, 1'b0, 2'd2);
    tick_to(1'b0, 1'b0, 1'b0, 2'd2);

    phase = 5;
    bus_if.cmp_eq = 1'b0;
    idle(3);
    bus_if.cmp_gt = 1'b1;
    bus_if.cmp_lt = 1'b1;
    bus_if.cmp_eq = 1'b1;
    idle(5);
    bus_if.cmp_gt = 1'b0;
    bus_if.cmp_lt = 1'b0;
    bus_if.cmp_eq = 1'b0;
    idle(3);
    bus_if.cmp_gt = 1'b1;
    bus_if.cmp_eq = 1'b1;
    idle(5);
    bus_if.cmp_gt = 1'b0;
    bus_if.cmp_eq = 1'b0;
    idle(3);
    bus_if.alarm_en = 1'b0;
    bus_if.cmp_eq = 1'b1;
    idle(5);
    bus_if.alarm_en = 1'b1;
    idle(5);

    phase = 6;
    bus_if.cmp_eq = 1'b0;
    idle(2);
    trigger();
    tick_to(1'b1, 1'b0, 1'b0, 2'd2);
    rst = 1'b1;
    bus_if.cmp_eq = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 2'd2);
    apply_stimulus();
    rst = 1'b0;
    idle(3);
    trigger();
    snooze_press(2'd1);
    tick_to(1'b0, 1'b1, 1'b0, 2'd1);
    rst = 1'b1;
    bus_if.cmp_eq = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 2'd2);
    apply_stimulus();
    rst = 1'b0;
    idle(3);
    trigger();
    snooze_press(2'd1);
    idle(4);
    bus_if.alarm_en = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 2'd1);
    apply_stimulus();
    idle(3);

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
